wb_mem_write_queue: RTL and testbench
=====================================

WB_MEM_WRITE_QUEUE -- requirements
Module: wb_mem_write_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of buffered store entries (power of two, 2..16).
REQ-002 SHALL have parameter PTR_W, default 3, log2(DEPTH).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mem_ld  input  1  enqueue request from writeback.
REQ-006 SHALL have port mem_addr  input  32  store byte address.
REQ-007 SHALL have port mem_data  input  64  store data, right-aligned.
REQ-008 SHALL have port memsize  input  2  store size: 00=1B, 01=2B, 10=4B, 11=8B.
REQ-009 SHALL have port inst_ptcid  input  7  ID of the storing instruction.
REQ-010 SHALL have port wbaq_full  output  1  queue holds DEPTH entries.
REQ-011 SHALL have port wbaq_count  output  PTR_W+1  number of valid entries.
REQ-012 SHALL have port dc_valid  output  1  head entry is presented to the dcache.
REQ-013 SHALL have port dc_ready  input  1  dcache accepts the head this cycle.
REQ-014 SHALL have ports dc_addr/dc_data/dc_size/dc_ptcid  output  32/64/2/7  head entry fields.
REQ-015 SHALL have ports probe_addr/probe_size  input  32/2  load-address probe from memory stage.
REQ-016 SHALL have port probe_hit  output  1  probe overlaps a valid queued store.

Function
REQ-017 SHALL be a circular FIFO with head pointer, tail pointer and count registers, pointers wrapping DEPTH-1 -> 0.
REQ-018 Enqueue SHALL occur on an edge where mem_ld=1 and wbaq_full=0; the entry is written at tail, tail and count advance.
REQ-019 mem_ld=1 while wbaq_full=1 SHALL be ignored (no write, no pointer change); writeback stalls upstream in this case.
REQ-020 Dequeue SHALL occur on an edge where dc_valid=1 and dc_ready=1; head advances, count decrements.
REQ-021 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-022 dc_valid SHALL equal (count != 0); dc_* fields SHALL be driven from the head entry registers (no bypass: entry enqueued at edge N is visible at dc_* after edge N).
REQ-023 dc_* fields SHALL hold stable while dc_valid=1 and dc_ready=0.
REQ-024 wbaq_full SHALL equal (count == DEPTH), combinationally from registered count.
REQ-025 dc_ready while empty SHALL have no effect.
REQ-026 probe_hit SHALL be combinational: 1 iff some valid entry (including the head being presented) has byte range [addr, addr+2^size-1] overlapping [probe_addr, probe_addr+2^probe_size-1].
REQ-027 Range ends SHALL be computed in 33 bits; no wrap past 0xFFFFFFFF.
REQ-028 Entries enqueued at the current edge SHALL not affect probe_hit until after that edge; an entry dequeued at the edge SHALL stop contributing after it.
REQ-029 Entry data SHALL be stored unchanged; no merging or coalescing of stores.

Reset
REQ-030 While rst=0, head, tail, count SHALL be 0 and all entry valid bits cleared, asynchronously.
REQ-031 During/after reset: wbaq_full=0, wbaq_count=0, dc_valid=0, probe_hit=0; dc_* data values are don't-care.
REQ-032 Reset asserted mid-operation SHALL discard all pending entries; first edge after rst=1 behaves as empty queue.

Verification
REQ-033 Fill: 8 enqueues (addr 0x100+8i, size 11), dc_ready=0 -> count=8, wbaq_full=1; 9th mem_ld ignored, entries unchanged.
REQ-034 Drain order: dc_ready=1 after fill -> dc_addr 0x100,0x108,...,0x138 on consecutive cycles, then dc_valid=0, count=0.
REQ-035 Wrap/simultaneous: count=4 with tail=7, enqueue+dequeue each cycle for 6 cycles -> count stays 4, tail wraps to 5, FIFO order preserved.
REQ-036 Probe: queued store addr 0x1003 size 00; probe 0x1000 size 10 -> hit=1; probe 0x1004 size 10 -> hit=0; probe 0xFFFFFFFC size 10 vs store 0x0 size 11 -> hit=0.
REQ-037 Stall hold: dc_valid=1, dc_ready=0 for 5 cycles -> dc_* constant, count constant.
REQ-038 Mid-op reset: count=5, drive rst=0 between edges -> count=0, dc_valid=0, probe_hit=0 immediately, before next edge.

Source files
------------

// File: rtl/wb_mem_write_queue.sv
// wb_mem_write_queue
//   Circular store buffer between writeback and the dcache. Stores are
//   queued in order. The head entry is presented on dc_* with a valid/ready
//   handshake. A combinational probe reports whether a load byte range
//   overlaps any queued store.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   mem_ld, mem_addr,        enqueue request with store address, data,
//   mem_data, memsize,       size (00=1B .. 11=8B) and instruction ID
//   inst_ptcid
//   wbaq_full, wbaq_count    occupancy status
//   dc_valid, dc_ready,      head entry handshake and fields
//   dc_addr, dc_data,
//   dc_size, dc_ptcid
//   probe_addr, probe_size,  load-address overlap probe
//   probe_hit
module wb_mem_write_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_ld,
  input  logic [31:0]      mem_addr,
  input  logic [63:0]      mem_data,
  input  logic [1:0]       memsize,
  input  logic [6:0]       inst_ptcid,
  output logic             wbaq_full,
  output logic [PTR_W:0]   wbaq_count,
  output logic             dc_valid,
  input  logic             dc_ready,
  output logic [31:0]      dc_addr,
  output logic [63:0]      dc_data,
  output logic [1:0]       dc_size,
  output logic [6:0]       dc_ptcid,
  input  logic [31:0]      probe_addr,
  input  logic [1:0]       probe_size,
  output logic             probe_hit
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;

  // Entry payload needs no reset: only valid_q decides whether it matters.
  logic [31:0] ent_addr_q  [DEPTH];
  logic [63:0] ent_data_q  [DEPTH];
  logic [1:0]  ent_size_q  [DEPTH];
  logic [6:0]  ent_ptcid_q [DEPTH];

  logic enq, deq;

  assign wbaq_full  = (count_q == DEPTH_C);
  assign wbaq_count = count_q;
  assign dc_valid   = (count_q != '0);
  assign dc_addr    = ent_addr_q[head_q];
  assign dc_data    = ent_data_q[head_q];
  assign dc_size    = ent_size_q[head_q];
  assign dc_ptcid   = ent_ptcid_q[head_q];

  assign enq = mem_ld && !wbaq_full;
  assign deq = dc_valid && dc_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (enq) begin
      tail_d          = tail_q + PTR_W'(1);
      valid_d[tail_q] = 1'b1;
    end
    if (deq) begin
      head_d          = head_q + PTR_W'(1);
      valid_d[head_q] = 1'b0;
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      ent_addr_q[tail_q]  <= mem_addr;
      ent_data_q[tail_q]  <= mem_data;
      ent_size_q[tail_q]  <= memsize;
      ent_ptcid_q[tail_q] <= inst_ptcid;
    end
  end

  // Inclusive range ends in 33 bits so a range near the top of the address
  // space cannot wrap around and falsely overlap low addresses.
  logic [32:0]      probe_lo, probe_hi;
  logic [DEPTH-1:0] ent_hit;

  assign probe_lo = {1'b0, probe_addr};
  assign probe_hi = probe_lo + (33'd1 << probe_size) - 33'd1;

  for (genvar g = 0; g < DEPTH; g++) begin : g_probe
    logic [32:0] ent_lo, ent_hi;
    assign ent_lo     = {1'b0, ent_addr_q[g]};
    assign ent_hi     = ent_lo + (33'd1 << ent_size_q[g]) - 33'd1;
    assign ent_hit[g] = valid_q[g] && (ent_lo <= probe_hi) && (probe_lo <= ent_hi);
  end

  assign probe_hit = |ent_hit;

endmodule

// File: tb/tb_wb_mem_write_queue.sv
module tb_wb_mem_write_queue;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             mem_ld;
  logic [31:0]      mem_addr;
  logic [63:0]      mem_data;
  logic [1:0]       memsize;
  logic [6:0]       inst_ptcid;
  logic             wbaq_full;
  logic [PTR_W:0]   wbaq_count;
  logic             dc_valid;
  logic             dc_ready;
  logic [31:0]      dc_addr;
  logic [63:0]      dc_data;
  logic [1:0]       dc_size;
  logic [6:0]       dc_ptcid;
  logic [31:0]      probe_addr;
  logic [1:0]       probe_size;
  logic             probe_hit;

  wb_mem_write_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst),
    .mem_ld(mem_ld), .mem_addr(mem_addr), .mem_data(mem_data),
    .memsize(memsize), .inst_ptcid(inst_ptcid),
    .wbaq_full(wbaq_full), .wbaq_count(wbaq_count),
    .dc_valid(dc_valid), .dc_ready(dc_ready),
    .dc_addr(dc_addr), .dc_data(dc_data), .dc_size(dc_size), .dc_ptcid(dc_ptcid),
    .probe_addr(probe_addr), .probe_size(probe_size), .probe_hit(probe_hit)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [63:0] d;
    logic [1:0]  s;
    logic [6:0]  p;
  } ent_t;

  ent_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("count", 64'(wbaq_count), 64'(sb.size()));
    chk("full", 64'(wbaq_full), 64'(sb.size() == DEPTH));
    chk("dc_valid", 64'(dc_valid), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("dc_addr", 64'(dc_addr), 64'(sb[0].a));
      chk("dc_data", dc_data, sb[0].d);
      chk("dc_size", 64'(dc_size), 64'(sb[0].s));
      chk("dc_ptcid", 64'(dc_ptcid), 64'(sb[0].p));
    end
  endtask

  // Inputs are stable from 1 time unit after the previous edge; the model
  // decides enqueue/dequeue from them, then compares just after the edge.
  task automatic step();
    bit   enq, deq;
    ent_t e;
    enq = mem_ld && (sb.size() < DEPTH);
    deq = dc_ready && (sb.size() != 0);
    e   = '{mem_addr, mem_data, memsize, inst_ptcid};
    @(posedge clk);
    if (deq) void'(sb.pop_front());
    if (enq) sb.push_back(e);
    #1;
    check_outputs();
  endtask

  task automatic drive_st(input logic [31:0] a, input logic [1:0] s, input logic [6:0] p);
    mem_ld     = 1'b1;
    mem_addr   = a;
    mem_data   = {$urandom, $urandom};
    memsize    = s;
    inst_ptcid = p;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; mem_ld = 1'b0; mem_addr = '0; mem_data = '0; memsize = '0;
    inst_ptcid = '0; dc_ready = 1'b0; probe_addr = 32'h100; probe_size = 2'b11;
    do_reset();
    check_outputs();
    chk("reset_probe", 64'(probe_hit), 64'd0);

    // Fill with dc_ready low, then a 9th request that must be dropped.
    for (int i = 0; i < DEPTH; i++) begin
      drive_st(32'h100 + 32'(8 * i), 2'b11, 7'(i));
      step();
    end
    drive_st(32'hDEAD_BEE0, 2'b11, 7'h7F);
    step();
    mem_ld = 1'b0;

    // Stall hold: head must not move while dc_ready is low.
    for (int i = 0; i < 5; i++) step();
    chk("stall_head", 64'(dc_addr), 64'h100);

    // Drain in order, then an extra ready while empty.
    dc_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_addr", 64'(dc_addr), 64'(32'h100 + 32'(8 * i)));
      step();
    end
    step();
    chk("empty_count", 64'(wbaq_count), 64'd0);

    // Build count=4 with tail=7, then 6 cycles of enqueue+dequeue (wrap).
    dc_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive_st(32'h2000 + 32'(16 * i), 2'(i), 7'(i + 10));
      step();
    end
    mem_ld = 1'b0; dc_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    dc_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_st(32'h3000 + 32'(4 * i), 2'b10, 7'(i + 40));
      step();
      chk("wrap_count", 64'(wbaq_count), 64'd4);
    end
    mem_ld = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("wrap_drained", 64'(dc_valid), 64'd0);

    // Probe overlap cases.
    do_reset();
    dc_ready = 1'b0;
    drive_st(32'h1003, 2'b00, 7'd1); step();
    drive_st(32'h0000_0000, 2'b11, 7'd2);
    probe_addr = 32'h0000_0004; probe_size = 2'b00; #1;
    chk("probe_before_edge", 64'(probe_hit), 64'd0);
    step();
    mem_ld = 1'b0;
    chk("probe_after_edge", 64'(probe_hit), 64'd1);
    probe_addr = 32'h1000; probe_size = 2'b10; #1;
    chk("probe_1000_w", 64'(probe_hit), 64'd1);
    probe_addr = 32'h1004; probe_size = 2'b10; #1;
    chk("probe_1004_w", 64'(probe_hit), 64'd0);
    probe_addr = 32'hFFFF_FFFC; probe_size = 2'b10; #1;
    chk("probe_top_nowrap", 64'(probe_hit), 64'd0);
    probe_addr = 32'h0000_0008; probe_size = 2'b00; #1;
    chk("probe_past_end", 64'(probe_hit), 64'd0);
    probe_addr = 32'h1003; probe_size = 2'b00;
    dc_ready = 1'b1; #1;
    chk("probe_head_live", 64'(probe_hit), 64'd1);
    step();
    dc_ready = 1'b0; #1;
    chk("probe_after_deq", 64'(probe_hit), 64'd0);

    // Mid-operation asynchronous reset.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_st(32'h4000 + 32'(8 * i), 2'b11, 7'(i));
      step();
    end
    mem_ld = 1'b0;
    chk("pre_reset_count", 64'(wbaq_count), 64'd5);
    probe_addr = 32'h4000; probe_size = 2'b00;
    #2;
    rst = 1'b0;
    #1;
    sb.delete();
    chk("async_count", 64'(wbaq_count), 64'd0);
    chk("async_valid", 64'(dc_valid), 64'd0);
    chk("async_probe", 64'(probe_hit), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive_st(32'h5000, 2'b01, 7'd9);
    step();
    mem_ld = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
